pipelined_block_lookahead_sub: RTL and testbench

//  Pipelined N-bit fixed-point subtractor: diff = a - b - bi, borrow-out bo.

---
 rtl/fixed_point_arith_pkg.sv | 17 +
 rtl/block_lookahead_sub_slice.sv | 44 ++++
 rtl/pipelined_block_lookahead_sub.sv | 155 +++++++++++++++
 tb/tb_pipelined_block_lookahead_sub.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_point_arith_pkg.sv
// Shared types, defaults and helpers for the fixed-point arithmetic datapaths.
package fixed_point_arith_pkg;

    localparam int unsigned N_DEFAULT   = 32;
    localparam int unsigned BLK_DEFAULT = 8;

    // One operand block at the default block width.
    typedef struct packed {
        logic [BLK_DEFAULT-1:0] bits;
    } blk_t;

    // Number of pipeline stages for an n-bit datapath split into blk-bit blocks.
    function automatic int unsigned stages(input int unsigned n, input int unsigned blk);
        return n / blk;
    endfunction

endpackage

// File: rtl/block_lookahead_sub_slice.sv
// Combinational BLK-bit subtract slice with generate/propagate borrow lookahead.
module block_lookahead_sub_slice #(
    parameter int unsigned BLK = 8
) (
    input  logic [BLK-1:0] a_blk,
    input  logic [BLK-1:0] b_blk,
    input  logic           bin,
    output logic [BLK-1:0] d_blk,
    output logic           bout,
    output logic           bmsb
);

    logic [BLK-1:0] g;
    logic [BLK-1:0] p;
    logic [BLK:0]   br;

    // A bit generates a borrow when a=0,b=1; it passes the incoming borrow when a==b.
    assign g = ~a_blk & b_blk;
    assign p = ~(a_blk ^ b_blk);

    // Flat lookahead: every borrow is a sum-of-products of g/p and bin, no ripple.
    always_comb begin
        logic bw;
        logic pp;
        br    = '0;
        bw    = 1'b0;
        pp    = 1'b0;
        br[0] = bin;
        for (int i = 0; i < int'(BLK); i++) begin
            bw = g[i];
            pp = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                bw = bw | (pp & g[j]);
                pp = pp & p[j];
            end
            br[i+1] = bw | (pp & bin);
        end
    end

    assign d_blk = a_blk ^ b_blk ^ br[BLK-1:0];
    assign bout  = br[BLK];
    assign bmsb  = br[BLK-1];

endmodule

// File: rtl/pipelined_block_lookahead_sub.sv
// Pipelined block-lookahead subtractor diff = a - b - bi with valid/ready flow control.
// Optional signed overflow flag enabled by defining FIXED_SUB_OVERFLOW_EN.
module pipelined_block_lookahead_sub
    import fixed_point_arith_pkg::*;
#(
    parameter int unsigned N   = N_DEFAULT,
    parameter int unsigned BLK = BLK_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bi,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         bo,
    output logic         out_ov
);

    localparam int unsigned STAGES = stages(N, BLK);

    if ((N % BLK) != 0) begin : g_bad_cfg
        $error("pipelined_block_lookahead_sub: N (%0d) must be a multiple of BLK (%0d)", N, BLK);
    end

    for (genvar k = 0; k < int'(STAGES); k++) begin : g_st
        localparam int unsigned DW = (k + 1) * BLK;

        logic [BLK-1:0] a_blk;
        logic [BLK-1:0] b_blk;
        logic [BLK-1:0] d_blk;
        logic           bin;
        logic           bout;
        logic           bmsb;
        logic           vin;
        logic           go;
        logic [DW-1:0]  d_in;
        logic [DW-1:0]  d_q;
        logic           bo_q;
        logic           v_q;

        // Stage 0 works straight off the ports; later stages consume the skewed operands.
        if (k == 0) begin : g_src
            assign a_blk = a[BLK-1:0];
            assign b_blk = b[BLK-1:0];
            assign bin   = bi;
            assign vin   = in_valid;
            assign d_in  = d_blk;
        end else begin : g_src
            assign a_blk = g_st[k-1].g_up.a_q[BLK-1:0];
            assign b_blk = g_st[k-1].g_up.b_q[BLK-1:0];
            assign bin   = g_st[k-1].bo_q;
            assign vin   = g_st[k-1].v_q;
            assign d_in  = {d_blk, g_st[k-1].d_q};
        end

        // Stage may load when empty or when its contents move on this cycle.
        if (k == int'(STAGES) - 1) begin : g_go
            assign go = ~v_q | out_ready;
        end else begin : g_go
            assign go = ~v_q | g_st[k+1].go;
        end

        block_lookahead_sub_slice #(
            .BLK(BLK)
        ) u_slice (
            .a_blk(a_blk),
            .b_blk(b_blk),
            .bin  (bin),
            .d_blk(d_blk),
            .bout (bout),
            .bmsb (bmsb)
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
            end else if (go) begin
                v_q <= vin;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                d_q  <= '0;
                bo_q <= 1'b0;
            end else if (go && vin) begin
                d_q  <= d_in;
                bo_q <= bout;
            end
        end

        // Operand blocks not yet consumed travel with the beat.
        if (k < int'(STAGES) - 1) begin : g_up
            localparam int unsigned UW = N - DW;
            logic [UW-1:0] a_nx;
            logic [UW-1:0] b_nx;
            logic [UW-1:0] a_q;
            logic [UW-1:0] b_q;

            if (k == 0) begin : g_nx
                assign a_nx = a[N-1:BLK];
                assign b_nx = b[N-1:BLK];
            end else begin : g_nx
                assign a_nx = g_st[k-1].g_up.a_q[UW+BLK-1:BLK];
                assign b_nx = g_st[k-1].g_up.b_q[UW+BLK-1:BLK];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (go && vin) begin
                    a_q <= a_nx;
                    b_q <= b_nx;
                end
            end
        end

`ifdef FIXED_SUB_OVERFLOW_EN
        // Signed overflow: borrow into the top bit differs from the borrow out of it.
        if (k == int'(STAGES) - 1) begin : g_ov
            logic ov_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ov_q <= 1'b0;
                end else if (go && vin) begin
                    ov_q <= bmsb ^ bout;
                end
            end
        end else begin : g_nc
            logic unused_bmsb;
            assign unused_bmsb = bmsb;
        end
`else
        logic unused_bmsb;
        assign unused_bmsb = bmsb;
`endif
    end

    assign in_ready  = g_st[0].go;
    assign out_valid = g_st[STAGES-1].v_q;
    assign diff      = g_st[STAGES-1].d_q;
    assign bo        = g_st[STAGES-1].bo_q;

`ifdef FIXED_SUB_OVERFLOW_EN
    assign out_ov = g_st[STAGES-1].g_ov.ov_q;
`else
    assign out_ov = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_block_lookahead_sub.sv
// Scoreboard bench for pipelined_block_lookahead_sub at N=32, BLK=8 (four stages).
module tb_pipelined_block_lookahead_sub;

    localparam int unsigned N = 32;

    typedef struct {
        logic [N-1:0] diff;
        logic         bo;
        logic         ov;
        int           cyc;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bi;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] diff;
    logic         bo;
    logic         out_ov;

    int     errors = 0;
    int     checks = 0;
    int     cyc    = 0;
    bit     lat_chk = 1'b1;
    bit     stalled = 1'b0;
    logic [N-1:0] held_diff;
    logic         held_bo;
    exp_t   pending;
    exp_t   sb[$];

    pipelined_block_lookahead_sub #(
        .N  (32),
        .BLK(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .bi       (bi),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .diff     (diff),
        .bo       (bo),
        .out_ov   (out_ov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [N-1:0] a_, input logic [N-1:0] b_, input logic bi_);
        exp_t m;
        logic [N:0]   w;
        logic [N+1:0] r;
        w = {1'b0, a_} - {1'b0, b_} - (N+1)'(bi_);
        r = {{2{a_[N-1]}}, a_} - {{2{b_[N-1]}}, b_} - (N+2)'(bi_);
        m.diff = w[N-1:0];
        m.bo   = w[N];
`ifdef FIXED_SUB_OVERFLOW_EN
        m.ov   = !((r[N+1:N-1] == 3'b000) || (r[N+1:N-1] == 3'b111));
`else
        m.ov   = 1'b0;
`endif
        m.cyc  = 0;
        return m;
    endfunction

    // One clock: sample handshakes mid-cycle, score, then advance past the edge.
    task automatic tick(output bit acc);
        bit   emit;
        exp_t e;
        @(negedge clk);
        acc  = in_valid && in_ready;
        emit = out_valid && out_ready;
        if (stalled) begin
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_diff", 64'(diff), 64'(held_diff));
            chk("stall_bo", 64'(bo), 64'(held_bo));
        end
        if (emit) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_output observed=%h expected=none", diff);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("diff", 64'(diff), 64'(e.diff));
                chk("bo", 64'(bo), 64'(e.bo));
                chk("out_ov", 64'(out_ov), 64'(e.ov));
                if (lat_chk) chk("latency", 64'(cyc - e.cyc), 64'd4);
            end
        end
        if (acc) begin
            e     = pending;
            e.cyc = cyc;
            sb.push_back(e);
        end
        stalled   = out_valid && !out_ready;
        held_diff = diff;
        held_bo   = bo;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [N-1:0] a_, input logic [N-1:0] b_, input logic bi_, input exp_t e);
        bit acc;
        int n;
        a        = a_;
        b        = b_;
        bi       = bi_;
        pending  = e;
        in_valid = 1'b1;
        acc      = 1'b0;
        n        = 0;
        while (!acc && n < 100) begin
            tick(acc);
            n++;
        end
        in_valid = 1'b0;
        chk("send_accepted", 64'(acc), 64'd1);
    endtask

    task automatic drain();
        bit acc;
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick(acc);
            n++;
        end
        tick(acc);
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        exp_t e;
        bit   acc;
        int   sent;
        int   n;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        bi        = 1'b0;
        pending   = model('0, '0, 1'b0);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_diff", 64'(diff), 64'd0);
        chk("rst_bo", 64'(bo), 64'd0);
        chk("rst_out_ov", 64'(out_ov), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Directed beats with spec-given expected results.
        e = '{diff: 32'h0000_0002, bo: 1'b0, ov: 1'b0, cyc: 0};
        send(32'd5, 32'd3, 1'b0, e);
        drain();
        e = '{diff: 32'hFFFF_FFFF, bo: 1'b1, ov: 1'b0, cyc: 0};
        send(32'd0, 32'd1, 1'b0, e);
        drain();
`ifdef FIXED_SUB_OVERFLOW_EN
        e = '{diff: 32'h7FFF_FFFF, bo: 1'b0, ov: 1'b1, cyc: 0};
`else
        e = '{diff: 32'h7FFF_FFFF, bo: 1'b0, ov: 1'b0, cyc: 0};
`endif
        send(32'h8000_0000, 32'd1, 1'b0, e);
        drain();
        e = '{diff: 32'hFFFF_FFFF, bo: 1'b1, ov: 1'b0, cyc: 0};
        send(32'h1234_5678, 32'h1234_5678, 1'b1, e);
        drain();

        // Back-to-back stream through the full pipe.
        e = '{diff: 32'hFFFF_FFFE, bo: 1'b1, ov: 1'b0, cyc: 0};
        send(32'd1, 32'd2, 1'b1, e);
        e = '{diff: 32'h0000_0000, bo: 1'b0, ov: 1'b0, cyc: 0};
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, e);
        e = '{diff: 32'h0001_0000, bo: 1'b0, ov: 1'b0, cyc: 0};
        send(32'h0001_00FF, 32'h0000_00FE, 1'b1, e);
        drain();

        // Random beats with random backpressure.
        lat_chk   = 1'b0;
        sent      = 0;
        n         = 0;
        a         = $urandom;
        b         = $urandom;
        bi        = 1'($urandom_range(0, 1));
        pending   = model(a, b, bi);
        in_valid  = 1'b1;
        while (sent < 1000 && n < 20000) begin
            out_ready = 1'($urandom_range(0, 1));
            tick(acc);
            n++;
            if (acc) begin
                sent++;
                a       = $urandom;
                b       = $urandom;
                bi      = 1'($urandom_range(0, 1));
                pending = model(a, b, bi);
            end
        end
        in_valid = 1'b0;
        chk("random_sent", 64'(sent), 64'd1000);
        drain();

        // Reset with three beats in flight.
        lat_chk   = 1'b1;
        out_ready = 1'b0;
        send(32'd10, 32'd1, 1'b0, model(32'd10, 32'd1, 1'b0));
        send(32'd20, 32'd2, 1'b0, model(32'd20, 32'd2, 1'b0));
        send(32'd30, 32'd3, 1'b0, model(32'd30, 32'd3, 1'b0));
        n = 0;
        while (!out_valid && n < 20) begin
            tick(acc);
            n++;
        end
        chk("pre_reset_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_diff", 64'(diff), 64'd0);
        sb.delete();
        stalled = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("post_reset_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        e = '{diff: 32'h0000_00FF, bo: 1'b0, ov: 1'b0, cyc: 0};
        send(32'h0000_0100, 32'd1, 1'b0, e);
        e = '{diff: 32'h0000_0063, bo: 1'b0, ov: 1'b0, cyc: 0};
        send(32'd100, 32'd0, 1'b1, e);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
